// File: rtl/rom_boot_sequencer.sv
// rom_boot_sequencer: loads 32-bit boot words into SRAM byte by byte, then hands the SRAM port to the core.
module rom_boot_sequencer #(
  parameter int ADDR_W    = 21,
  parameter int BASE_ADDR = 0,
  parameter int ROM_BYTES = 49152,
  parameter int WE_PULSE  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       host_bootdata,
  input  logic              host_bootdata_req,
  output logic              host_bootdata_ack,
  output logic              host_rom_initialised,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_dout,
  input  logic              core_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_we_n,
  output logic              busy
);
  localparam int CW = $clog2(WE_PULSE + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + ROM_BYTES - 1);
  localparam logic [CW-1:0] CLAST = CW'(WE_PULSE - 1);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sram_addr_q, sram_addr_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic ack_q, ack_d, init_q, init_d, busy_q, busy_d, we_n_q, we_n_d, accept;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    accept  = state_q == IDLE && host_bootdata_req && !ack_q;
    case (state_q)
      IDLE: if (accept) begin
        word_d  = host_bootdata;
        idx_d   = 2'd0;
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: if (cnt_q == CLAST) state_d = HOLD;
              else cnt_d = cnt_q + 1'b1;
      HOLD: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST) state_d = DONE;
        else if (idx_q != 2'd3) begin
          idx_d   = idx_q + 1'b1;
          state_d = SETUP;
        end else state_d = IDLE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    ack_d       = ack_q ? host_bootdata_req : accept;
    busy_d      = state_d == SETUP || state_d == STROBE || state_d == HOLD;
    init_d      = state_d == DONE;
    we_n_d      = state_d != STROBE;
    sram_addr_d = addr_d;
    // Registered SRAM outputs track the byte the next cycle will present.
    dout_d = idx_d == 2'd0 ? word_d[31:24] :
             idx_d == 2'd1 ? word_d[23:16] :
             idx_d == 2'd2 ? word_d[15:8]  : word_d[7:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      addr_q      <= BASE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      we_n_q      <= 1'b1;
      dout_q      <= 8'd0;
      sram_addr_q <= BASE;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      init_q      <= init_d;
      busy_q      <= busy_d;
      we_n_q      <= we_n_d;
      dout_q      <= dout_d;
      sram_addr_q <= sram_addr_d;
    end
  assign host_bootdata_ack    = ack_q;
  assign host_rom_initialised = init_q;
  assign busy                 = busy_q;
  assign sram_addr            = init_q ? core_addr : sram_addr_q;
  assign sram_dout            = init_q ? core_dout : dout_q;
  assign sram_we_n            = init_q ? core_we_n : we_n_q;
endmodule

// File: tb/tb_rom_boot_sequencer.sv
// tb_rom_boot_sequencer: directed checks on three instances (full image, 8-byte image, 6-byte image).
module tb_rom_boot_sequencer;
  logic clk = 1'b0;
  logic reset, req, core_we_n;
  logic [31:0] data;
  logic [20:0] core_addr;
  logic [7:0] core_dout;
  logic [20:0] a_addr, b_addr, c_addr;
  logic [7:0] a_dout, b_dout, c_dout;
  logic a_we, b_we, c_we, a_ack, b_ack, c_ack, a_init, b_init, c_init, a_busy, b_busy, c_busy;
  int passed = 0, total = 0;
  int nlog [3] = '{0, 0, 0};
  logic [20:0] la [3][64];
  logic [7:0] ld [3][64];
  int ll [3][64];
  bit ls [3][64];
  logic pwe [3] = '{1'b1, 1'b1, 1'b1};
  logic [20:0] pa [3];
  logic [7:0] pd [3];
  int len [3];
  bit st [3];

  always #5 clk = ~clk;

  rom_boot_sequencer u_a (
    .clk(clk), .reset(reset), .host_bootdata(data), .host_bootdata_req(req),
    .host_bootdata_ack(a_ack), .host_rom_initialised(a_init),
    .core_addr(core_addr), .core_dout(core_dout), .core_we_n(core_we_n),
    .sram_addr(a_addr), .sram_dout(a_dout), .sram_we_n(a_we), .busy(a_busy));
  rom_boot_sequencer #(.ROM_BYTES(8)) u_b (
    .clk(clk), .reset(reset), .host_bootdata(data), .host_bootdata_req(req),
    .host_bootdata_ack(b_ack), .host_rom_initialised(b_init),
    .core_addr(core_addr), .core_dout(core_dout), .core_we_n(core_we_n),
    .sram_addr(b_addr), .sram_dout(b_dout), .sram_we_n(b_we), .busy(b_busy));
  rom_boot_sequencer #(.ROM_BYTES(6)) u_c (
    .clk(clk), .reset(reset), .host_bootdata(data), .host_bootdata_req(req),
    .host_bootdata_ack(c_ack), .host_rom_initialised(c_init),
    .core_addr(core_addr), .core_dout(core_dout), .core_we_n(core_we_n),
    .sram_addr(c_addr), .sram_dout(c_dout), .sram_we_n(c_we), .busy(c_busy));

  // Logs each completed we_n pulse with its address, data, low length and whether addr/data held from setup through hold.
  task automatic mon(input int k, input logic we, input logic [20:0] a, input logic [7:0] d);
    if (pwe[k] && !we) begin
      len[k] = 1;
      st[k] = (a === pa[k]) && (d === pd[k]);
    end else if (!pwe[k] && !we) begin
      len[k] = len[k] + 1;
      st[k] = st[k] && (a === pa[k]) && (d === pd[k]);
    end else if (!pwe[k] && we) begin
      la[k][nlog[k] % 64] = pa[k];
      ld[k][nlog[k] % 64] = pd[k];
      ll[k][nlog[k] % 64] = len[k];
      ls[k][nlog[k] % 64] = st[k] && (a === pa[k]) && (d === pd[k]);
      nlog[k] = nlog[k] + 1;
    end
    pwe[k] = we;
    pa[k] = a;
    pd[k] = d;
  endtask

  always @(negedge clk) begin
    mon(0, a_we, a_addr, a_dout);
    mon(1, b_we, b_addr, b_dout);
    mon(2, c_we, c_addr, c_dout);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_log(input string tag, input int k, input int base, input int n,
                           input int a0, input logic [63:0] exp);
    chk($sformatf("%s_count", tag), nlog[k] - base, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {11'd0, la[k][(base + i) % 64]}, a0 + i);
      chk($sformatf("%s_data%0d", tag, i), {24'd0, ld[k][(base + i) % 64]}, {24'd0, exp[8*(n-1-i) +: 8]});
      chk($sformatf("%s_len%0d", tag, i), ll[k][(base + i) % 64], 2);
      chk($sformatf("%s_stable%0d", tag, i), {31'd0, ls[k][(base + i) % 64]}, 1);
    end
  endtask

  initial begin
    int b0, b1, c1, nb, db, dc, cnt, na;
    reset = 1'b1; req = 1'b0; data = '0; core_addr = '0; core_dout = '0; core_we_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_ack", a_ack, 0);
    chk("rst_init", a_init, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_we_n", a_we, 1);
    chk("rst_dout", a_dout, 0);
    chk("rst_addr", a_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    // single pulsed word
    b0 = nlog[0];
    data = 32'h11223344; req = 1'b1;
    @(negedge clk);
    chk("t1_ack", a_ack, 1);
    chk("t1_setup_addr", a_addr, 0);
    chk("t1_setup_dout", a_dout, 8'h11);
    chk("t1_setup_we_n", a_we, 1);
    req = 1'b0;
    nb = a_busy;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1_ack_clr", a_ack, 0);
      nb += a_busy;
    end
    chk("t1_busy_cycles", nb, 16);
    check_log("t1", 0, b0, 4, 0, 64'h11223344);
    // req held high: exactly one word consumed
    b0 = nlog[0];
    data = 32'hDEADBEEF; req = 1'b1;
    @(negedge clk);
    chk("t2_ack_rise", a_ack, 1);
    repeat (39) @(negedge clk);
    chk("t2_ack_held", a_ack, 1);
    req = 1'b0;
    @(negedge clk);
    chk("t2_ack_fall", a_ack, 0);
    repeat (20) @(negedge clk);
    check_log("t2", 0, b0, 4, 4, 64'hDEADBEEF);
    chk("t2_busy", a_busy, 0);
    // 8- and 6-byte images
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    core_addr = 21'h1234; core_dout = 8'h5A; core_we_n = 1'b0;
    #1;
    chk("t3_core_blocked_we", b_we, 1);
    chk("t3_core_blocked_addr", b_addr, 0);
    core_we_n = 1'b1;
    @(negedge clk);
    b1 = nlog[1]; c1 = nlog[2];
    data = 32'hAABBCCDD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    data = 32'h01020304; req = 1'b1;
    cnt = 0; db = 0; dc = 0;
    while ((db == 0 || dc == 0) && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) req = 1'b0;
      if (db == 0 && b_init) db = cnt;
      if (dc == 0 && c_init) dc = cnt;
    end
    chk("t3_done_cycle", db, 17);
    chk("t4_done_cycle", dc, 9);
    repeat (10) @(negedge clk);
    check_log("t3", 1, b1, 8, 0, 64'hAABBCCDD01020304);
    check_log("t4", 2, c1, 6, 0, 64'h0000AABBCCDD0102);
    chk("t3_busy_done", b_busy, 0);
    chk("t3_init", b_init, 1);
    core_addr = 21'h1234; core_dout = 8'h5A; core_we_n = 1'b0;
    #1;
    chk("t3_pt_addr", b_addr, 21'h1234);
    chk("t3_pt_dout", b_dout, 8'h5A);
    chk("t3_pt_we_lo", b_we, 0);
    core_we_n = 1'b1;
    #1;
    chk("t3_pt_we_hi", b_we, 1);
    @(negedge clk);
    // reset during strobe of the third byte
    data = 32'h55667788; req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
    end
    chk("t5_in_strobe", a_we, 0);
    chk("t5_strobe_addr", a_addr, 10);
    reset = 1'b1;
    #1;
    chk("t5_rst_we_n", a_we, 1);
    chk("t5_rst_addr", a_addr, 0);
    chk("t5_rst_dout", a_dout, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_ack", a_ack, 0);
    chk("t5_rst_init", b_init, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b0 = nlog[0];
    data = 32'hCAFEF00D; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    check_log("t5", 0, b0, 4, 0, 64'hCAFEF00D);
    // requests after done are ignored
    data = 32'h12345678; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_init", b_init, 1);
    b1 = nlog[1];
    data = 32'hFFFFFFFF; req = 1'b1;
    na = 0;
    repeat (10) begin
      @(negedge clk);
      na += b_ack;
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_ack_stays_0", na, 0);
    chk("t6_no_write", nlog[1] - b1, 0);
    core_we_n = 1'b0;
    #1;
    chk("t6_core_we", b_we, 0);
    core_we_n = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rom_boot_sequencer.md
Name: rom_boot_sequencer

Overview:
- Sequences ROM image loading from the control module into the shared SRAM before the CPC core starts.
- Accepts 32-bit boot words over the host_bootdata req/ack handshake and unpacks each into four timed byte writes.
- Owns the SRAM port until the image is complete, then asserts host_rom_initialised and hands the port to the core's address/data/write-enable lines.

Parameters:
ADDR_W, 21, SRAM address width
BASE_ADDR, 0, SRAM address of the first image byte
ROM_BYTES, 49152, image length in bytes (OS + BASIC + AMSDOS)
WE_PULSE, 2, sram_we_n low time in clk cycles per byte, >=1

Ports:
clk  in  1  system clock (ck16 domain)
reset  in  1  asynchronous, active-high reset
host_bootdata  in  32  boot word; valid while host_bootdata_req=1
host_bootdata_req  in  1  host word-valid request (4-phase)
host_bootdata_ack  out  1  word accepted; held until req seen low
host_rom_initialised  out  1  image fully written; port handed to core
core_addr  in  ADDR_W  core SRAM address
core_dout  in  8  core SRAM write data
core_we_n  in  1  core SRAM write enable, active low
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  8  SRAM write data
sram_we_n  out  1  SRAM write enable, active low
busy  out  1  1 while a word is being written

Behaviour:
- Reset (async, active-high): state IDLE, byte address=BASE_ADDR, byte index=0, host_bootdata_ack=0, host_rom_initialised=0, busy=0, sram_we_n=1, sram_dout=0, sram_addr=BASE_ADDR. Reset mid-write abandons the byte immediately (we_n returns to 1 asynchronously), and loading restarts from BASE_ADDR on the next word.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: accept a word when req=1 and ack=0. Latch host_bootdata, set ack=1 and busy=1 on the next edge, byte index=0, go to SETUP.
- ack clears on the first edge at which req is sampled 0. Another word is never accepted while ack=1, so a req held high consumes exactly one word.
- Byte order: MSB first. Bits [31:24] go to the current address, [23:16] to +1, [15:8] to +2, [7:0] to +3.
- SETUP, 1 cycle: sram_addr/sram_dout drive the byte, we_n=1.
- STROBE, WE_PULSE cycles: we_n=0; address and data stable.
- HOLD, 1 cycle: we_n=1; address and data stable. Then the address increments.
  - If the byte just written was BASE_ADDR+ROM_BYTES-1, go to DONE.
  - Else if byte index<3, increment it and go to SETUP.
  - Else go to IDLE with busy=0.
- Cost per byte is WE_PULSE+2 cycles; per word 4*(WE_PULSE+2). The first SETUP cycle follows the accept edge.
- Partial last word: when ROM_BYTES is not a multiple of 4, the remaining bytes of the final word are discarded, not written.
- DONE:
  - host_rom_initialised=1 (registered, rises on the edge entering DONE); busy=0.
  - Pass-through is combinational: sram_addr=core_addr, sram_dout=core_dout, sram_we_n=core_we_n.
  - Further req is ignored and ack stays 0 once cleared. Only reset leaves DONE.
- Before DONE, core_* inputs are ignored and the core cannot reach SRAM.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. ROM_BYTES is sized so no wrap occurs in normal use.
- All outputs are registered except in DONE.

Test Plan:
- WE_PULSE=2, word 0x11223344, req pulsed → writes 0x11@0, 0x22@1, 0x33@2, 0x44@3.
  - Each write has we_n low exactly 2 cycles, with a 1-cycle setup and 1-cycle hold of stable addr/data.
  - busy is high for 16 cycles.
- req held high 40 cycles with a constant word → exactly 4 bytes written. ack rises 1 cycle after accept and falls 1 cycle after req is sampled 0. No second word is accepted.
- ROM_BYTES=8, words 0xAABBCCDD and 0x01020304 → bytes at 0..7 correct; host_rom_initialised rises on the edge after the final HOLD.
  - Core writes 0x5A@0x1234 then pass through to sram_* in the same cycle.
- ROM_BYTES=6, two words → bytes 0..5 written; the last two bytes of word 2 are never strobed; done asserts after address 5.
- Reset asserted during STROBE of byte 2 → sram_we_n=1 immediately and all outputs at reset values. A new word afterwards writes from address 0.
- After DONE, req=1 with any data → ack stays 0, no SRAM write from the sequencer, and core_we_n still controls sram_we_n.
